// File: rtl/hangman_ctrl.sv
// hangman_ctrl: two-player word-guessing round controller.
// The setter loads a word one letter per strobe. The guesser submits one
// letter at a time, and each guess is checked against the stored word one
// index per cycle. The round ends in WIN when every letter is revealed and in
// LOSE after MISS_MAX misses. Both end states hold until wipe.
// Optional turn timer: define HANGMAN_TIMEOUT_EN. A READY phase that lasts
// TURN_CYC cycles is then judged as a miss.
module hangman_ctrl #(
    parameter int unsigned WORD_MAX = 16,
    parameter int unsigned MISS_MAX = 9,
    parameter int unsigned CHAR_W   = 5,
    parameter int unsigned TURN_CYC = 1024,
    parameter int unsigned SCORE_W  = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          load_valid,
    input  logic [CHAR_W-1:0]             load_char,
    input  logic                          load_done,
    input  logic                          guess_valid,
    input  logic [CHAR_W-1:0]             guess_char,
    input  logic                          wipe,
    output logic                          guess_ready,
    output logic [$clog2(WORD_MAX+1)-1:0] word_len,
    output logic [WORD_MAX-1:0]           revealed,
    output logic [$clog2(WORD_MAX+1)-1:0] remain,
    output logic [3:0]                    miss_cnt,
    output logic                          hit,
    output logic                          miss,
    output logic                          timeout,
    output logic [2:0]                    state,
    output logic                          win,
    output logic                          lose,
    output logic [SCORE_W-1:0]            p1score,
    output logic [SCORE_W-1:0]            p2score
);

    localparam int unsigned LW = $clog2(WORD_MAX + 1);
    localparam int unsigned IW = $clog2(WORD_MAX);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_READY = 3'd1,
        S_SCAN  = 3'd2,
        S_JUDGE = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    state_t            st;
    logic [CHAR_W-1:0] word_mem [WORD_MAX];
    logic [CHAR_W-1:0] guess_q;
    logic [IW-1:0]     idx;
    logic              found;

    logic              load_take;
    logic [LW-1:0]     len_next;
    logic              match;
    logic              found_all;
    logic              last_idx;

`ifdef HANGMAN_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TURN_CYC);
    logic [TW-1:0]     tmr;
`else
    assign timeout = 1'b0;
`endif

    // Flags are plain decodes of the state register
    assign state       = st;
    assign guess_ready = (st == S_READY);
    assign win         = (st == S_WIN);
    assign lose        = (st == S_LOSE);

    // Load acceptance, and compare of the current scan letter against the latched guess
    always_comb begin
        load_take = load_valid && (word_len < LW'(WORD_MAX));
        len_next  = word_len + LW'(load_take);
        match     = (word_mem[idx] == guess_q) && !revealed[idx];
        found_all = found || match;
        last_idx  = (LW'(idx) == (word_len - LW'(1)));
    end

    // Word storage; the contents after reset do not matter
    always_ff @(posedge clk) begin
        if ((st == S_LOAD) && !wipe && load_take) begin
            word_mem[IW'(word_len)] <= load_char;
        end
    end

    // Round FSM and its registered counters, pulses and scores
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st       <= S_LOAD;
            word_len <= '0;
            revealed <= '0;
            remain   <= '0;
            miss_cnt <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            p1score  <= '0;
            p2score  <= '0;
            guess_q  <= '0;
            idx      <= '0;
            found    <= 1'b0;
`ifdef HANGMAN_TIMEOUT_EN
            tmr      <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
`ifdef HANGMAN_TIMEOUT_EN
            timeout <= 1'b0;
            if (st != S_READY) tmr <= '0;
`endif
            if (wipe) begin
                st       <= S_LOAD;
                word_len <= '0;
                revealed <= '0;
                remain   <= '0;
                miss_cnt <= '0;
                idx      <= '0;
                found    <= 1'b0;
            end else begin
                case (st)
                    S_LOAD: begin
                        word_len <= len_next;
                        if (load_done && (len_next != '0)) begin
                            st     <= S_READY;
                            remain <= len_next;
                        end
                    end
                    S_READY: begin
                        if (guess_valid) begin
                            guess_q <= guess_char;
                            idx     <= '0;
                            found   <= 1'b0;
                            st      <= S_SCAN;
`ifdef HANGMAN_TIMEOUT_EN
                            tmr     <= '0;
                        end else if (tmr == TW'(TURN_CYC - 1)) begin
                            timeout  <= 1'b1;
                            miss     <= 1'b1;
                            miss_cnt <= miss_cnt + 4'd1;
                            st       <= S_JUDGE;
                        end else begin
                            tmr <= tmr + TW'(1);
`endif
                        end
                    end
                    S_SCAN: begin
                        if (match) begin
                            revealed[idx] <= 1'b1;
                            remain        <= remain - LW'(1);
                        end
                        found <= found_all;
                        if (last_idx) begin
                            st   <= S_JUDGE;
                            hit  <= found_all;
                            miss <= !found_all;
                            if (!found_all) miss_cnt <= miss_cnt + 4'd1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                    S_JUDGE: begin
                        if (remain == '0) begin
                            st <= S_WIN;
                            if (p2score != '1) p2score <= p2score + SCORE_W'(1);
                        end else if (miss_cnt == 4'(MISS_MAX)) begin
                            st <= S_LOSE;
                            if (p1score != '1) p1score <= p1score + SCORE_W'(1);
                        end else begin
                            st <= S_READY;
                        end
                    end
                    S_WIN, S_LOSE: begin
                        st <= st;
                    end
                    default: begin
                        st <= S_LOAD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hangman_ctrl.sv
// tb_hangman_ctrl: directed bench for hangman_ctrl. It keeps a transaction-level
// model of the round: the word is held in an array, and a guess is resolved in
// one step when it is accepted. The outputs are compared with the model on
// every cycle, and literal checks at key points pin the model itself.
module tb_hangman_ctrl;

    localparam int unsigned WM = 8;
    localparam int unsigned MM = 3;
    localparam int unsigned CW = 5;
    localparam int unsigned TC = 16;
    localparam int unsigned SW = 4;

    localparam int S_LOAD  = 0;
    localparam int S_READY = 1;
    localparam int S_SCAN  = 2;
    localparam int S_JUDGE = 3;
    localparam int S_WIN   = 4;
    localparam int S_LOSE  = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          load_valid, load_done, guess_valid, wipe;
    logic [CW-1:0] load_char, guess_char;
    logic          guess_ready, hit, miss, timeout, win, lose;
    logic [3:0]    word_len, remain, miss_cnt;
    logic [WM-1:0] revealed;
    logic [2:0]    state;
    logic [SW-1:0] p1score, p2score;

    hangman_ctrl #(
        .WORD_MAX(WM), .MISS_MAX(MM), .CHAR_W(CW), .TURN_CYC(TC), .SCORE_W(SW)
    ) dut (
        .clk(clk), .resetn(resetn),
        .load_valid(load_valid), .load_char(load_char), .load_done(load_done),
        .guess_valid(guess_valid), .guess_char(guess_char), .wipe(wipe),
        .guess_ready(guess_ready), .word_len(word_len), .revealed(revealed),
        .remain(remain), .miss_cnt(miss_cnt), .hit(hit), .miss(miss),
        .timeout(timeout), .state(state), .win(win), .lose(lose),
        .p1score(p1score), .p2score(p2score)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model of the round as it should look after the most recent clock edge
    int            m_state, m_len, m_remain, m_miss, m_p1, m_p2, m_idle, m_scan_left;
    bit            m_hit, m_missp, m_to, p_found;
    int            m_word [WM];
    logic [WM-1:0] m_rev, p_rev;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_LOAD; m_len = 0; m_remain = 0; m_miss = 0;
        m_p1 = 0; m_p2 = 0; m_idle = 0; m_scan_left = 0;
        m_hit = 0; m_missp = 0; m_to = 0; m_rev = '0;
    endtask

    // Advance the model across one clock edge, given the inputs applied for that edge
    task automatic predict(input bit lv, input int lc, input bit ld, input bit gv, input int gc, input bit wp);
        m_hit = 0; m_missp = 0; m_to = 0;
        if (!resetn) begin
            model_reset();
            return;
        end
        if (wp) begin
            m_state = S_LOAD; m_len = 0; m_rev = '0; m_remain = 0; m_miss = 0;
            return;
        end
        case (m_state)
            S_LOAD: begin
                if (lv && m_len < int'(WM)) begin
                    m_word[m_len] = lc;
                    m_len++;
                end
                if (ld && m_len > 0) begin
                    m_state = S_READY; m_remain = m_len; m_idle = 0;
                end
            end
            S_READY: begin
                if (gv) begin
                    p_rev = m_rev; p_found = 0;
                    for (int i = 0; i < m_len; i++) begin
                        if (m_word[i] == gc && !p_rev[i]) begin
                            p_rev[i] = 1'b1; p_found = 1;
                        end
                    end
                    m_scan_left = m_len; m_state = S_SCAN;
                end else begin
`ifdef HANGMAN_TIMEOUT_EN
                    m_idle++;
                    if (m_idle == int'(TC)) begin
                        m_state = S_JUDGE; m_to = 1; m_missp = 1; m_miss++;
                    end
`endif
                end
            end
            S_SCAN: begin
                m_scan_left--;
                if (m_scan_left == 0) begin
                    m_state = S_JUDGE;
                    m_rev = p_rev;
                    m_remain = m_len - $countones(p_rev);
                    if (p_found) m_hit = 1;
                    else begin m_missp = 1; m_miss++; end
                end
            end
            S_JUDGE: begin
                if (m_remain == 0) begin
                    m_state = S_WIN; if (m_p2 < 15) m_p2++;
                end else if (m_miss == int'(MM)) begin
                    m_state = S_LOSE; if (m_p1 < 15) m_p1++;
                end else begin
                    m_state = S_READY; m_idle = 0;
                end
            end
            default: ;
        endcase
    endtask

    // Compare every DUT output with the model; letters mid-scan are in flux
    task automatic compare_model();
        check("state", int'(state), m_state);
        check("guess_ready", int'(guess_ready), int'(m_state == S_READY));
        check("win", int'(win), int'(m_state == S_WIN));
        check("lose", int'(lose), int'(m_state == S_LOSE));
        check("word_len", int'(word_len), m_len);
        check("miss_cnt", int'(miss_cnt), m_miss);
        check("p1score", int'(p1score), m_p1);
        check("p2score", int'(p2score), m_p2);
        check("hit", int'(hit), int'(m_hit));
        check("miss", int'(miss), int'(m_missp));
        check("timeout", int'(timeout), int'(m_to));
        if (m_state != S_SCAN) begin
            check("revealed", int'(revealed), int'(m_rev));
            check("remain", int'(remain), m_remain);
        end
    endtask

    // One clock cycle: compare at the falling edge, then drive the next inputs and predict
    task automatic cyc(input bit lv, input int lc, input bit ld, input bit gv, input int gc, input bit wp);
        @(negedge clk);
        compare_model();
        #1;
        load_valid = lv; load_char = CW'(lc); load_done = ld;
        guess_valid = gv; guess_char = CW'(gc); wipe = wp;
        predict(lv, lc, ld, gv, gc, wp);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
    endtask
    task automatic load(input int c);  cyc(1, c, 0, 0, 0, 0); endtask
    task automatic done();             cyc(0, 0, 1, 0, 0, 0); endtask
    task automatic guess(input int c); cyc(0, 0, 0, 1, c, 0); endtask
    task automatic do_wipe();          cyc(0, 0, 0, 0, 0, 1); endtask

    initial begin
        resetn = 1'b0;
        load_valid = 0; load_char = '0; load_done = 0;
        guess_valid = 0; guess_char = '0; wipe = 0;
        model_reset();
        #3;
        check("rst_state", int'(state), 0);
        check("rst_scores", int'(p1score) + int'(p2score), 0);
        check("rst_word_len", int'(word_len), 0);
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;

        // Word 1,2,1: a guess of 1 reveals two letters, then 2 wins
        load(1); load(2); load(1); done(); idle(1);
        check("ready_after_load", int'(state), S_READY);
        check("remain_after_load", int'(remain), 3);
        guess(1); idle(3);
        check("still_scan", int'(state), S_SCAN);
        idle(1);
        check("judge_latency", int'(state), S_JUDGE);
        check("judge_hit", int'(hit), 1);
        check("revealed_101", int'(revealed), 5);
        check("remain_1", int'(remain), 1);
        idle(1);
        guess(2); idle(4);
        check("hit_2", int'(hit), 1);
        idle(1);
        check("win_state", int'(state), S_WIN);
        check("p2score_1", int'(p2score), 1);
        idle(3);
        check("win_hold", int'(win), 1);

        // Word 1,2: three misses lose the round; the score survives wipe
        do_wipe(); load(1); load(2); done(); idle(1);
        for (int k = 1; k <= 3; k++) begin
            guess(7); idle(3);
            check("miss_pulse", int'(miss), 1);
            check("miss_cnt_step", int'(miss_cnt), k);
            idle(1);
        end
        check("lose_state", int'(state), S_LOSE);
        check("p1score_1", int'(p1score), 1);
        guess(1); idle(2);
        check("lose_hold", int'(state), S_LOSE);
        do_wipe(); idle(1);
        check("wipe_load", int'(state), S_LOAD);
        check("wipe_miss_cnt", int'(miss_cnt), 0);
        check("wipe_keeps_p1", int'(p1score), 1);

        // A repeated guess of an already revealed letter counts as a miss
        load(1); load(2); done(); idle(1);
        guess(1); idle(3);
        check("first_hit", int'(hit), 1);
        idle(1);
        guess(1); idle(3);
        check("repeat_miss", int'(miss), 1);
        check("repeat_miss_cnt", int'(miss_cnt), 1);
        check("repeat_revealed", int'(revealed), 1);
        idle(1);

        // Turn timer behaviour in READY
        do_wipe(); load(3); load(4); done(); idle(1);
`ifdef HANGMAN_TIMEOUT_EN
        idle(15);
        check("no_early_timeout", int'(state), S_READY);
        idle(1);
        check("timeout_judge", int'(state), S_JUDGE);
        check("timeout_pulse", int'(timeout), 1);
        check("timeout_miss_cnt", int'(miss_cnt), 1);
        idle(2);
`else
        idle(100);
        check("ready_held", int'(state), S_READY);
        check("timeout_tied", int'(timeout), 0);
`endif

        // Load boundaries and wipe priority
        do_wipe(); idle(1);
        done(); idle(1);
        check("empty_done_stays", int'(state), S_LOAD);
        for (int c = 1; c <= 9; c++) load(c);
        idle(1);
        check("word_len_cap", int'(word_len), 8);
        done(); idle(1);
        check("remain_8", int'(remain), 8);
        cyc(0, 0, 0, 1, 1, 1); idle(1);
        check("wipe_beats_guess", int'(state), S_LOAD);
        check("wipe_len", int'(word_len), 0);
        cyc(1, 5, 1, 0, 0, 0); idle(1);
        check("load_and_done", int'(state), S_READY);
        check("load_and_done_len", int'(word_len), 1);

        // Asynchronous reset in the middle of a scan
        guess(5); idle(1);
        check("pre_reset_scan", int'(state), S_SCAN);
        resetn = 1'b0;
        model_reset();
        #1;
        check("async_rst_state", int'(state), S_LOAD);
        check("async_rst_p2", int'(p2score), 0);
        check("async_rst_p1", int'(p1score), 0);
        check("async_rst_revealed", int'(revealed), 0);
        idle(2);
        resetn = 1'b1;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
